// File: rtl/coreuart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coreuart_pkg
// Purpose  : Shared CoreUART definitions: TX drain state encoding, oversample
//            and read-latency defaults, data-width constants, and the frame
//            parity helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package coreuart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } tx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int RD_LATENCY_DEF = 2;
    localparam int DATA_W         = 8;
    localparam int DATA_W7        = 7;

    // Parity over the bits actually sent; bit 7 is dropped in 7-bit mode.
    // Even parity is the plain XOR, odd parity inverts it.
    function automatic logic frame_parity(input logic [DATA_W-1:0] data,
                                          input logic              bit8,
                                          input logic              odd);
        logic [DATA_W-1:0] m;
        m = bit8 ? data : {1'b0, data[DATA_W7-1:0]};
        return (^m) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain_if
// Purpose  : TX FIFO read-port bundle between the FIFO and the drain engine.
// Signals  : FIFO_EMPTY - FIFO empty flag (FIFO -> drain)
//            FIFO_DATA  - FIFO read data, 8 bits (FIFO -> drain)
//            FIFO_RDB   - active-low read strobe (drain -> FIFO)
// Modports : master - drain engine side; slave - FIFO side
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_drain_if;
    import coreuart_pkg::*;

    logic              FIFO_EMPTY;
    logic [DATA_W-1:0] FIFO_DATA;
    logic              FIFO_RDB;

    modport master (input FIFO_EMPTY, input FIFO_DATA, output FIFO_RDB);
    modport slave  (output FIFO_EMPTY, output FIFO_DATA, input FIFO_RDB);

endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_drain
// Purpose  : Drains bytes from the TX FIFO and serialises each one LSB-first
//            as start, 7/8 data, optional parity and one stop bit, timed by
//            the shared 16x baud enable.
// Ports    : CLK        - system clock
//            RESET_N    - synchronous reset, active low
//            BAUD_EN    - one-cycle pulse at OVERSAMPLE x baud rate
//            BIT8       - 1 = 8 data bits, 0 = 7 data bits
//            PARITY_EN  - 1 = append parity bit
//            ODD_N_EVEN - 1 = odd parity, 0 = even parity
//            fifo       - FIFO read port (EMPTY, DATA in; RDB out)
//            TX         - serial output, idle high
//            TX_BUSY    - high from read strobe through end of stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_drain
    import coreuart_pkg::*;
#(
    parameter int RD_LATENCY = RD_LATENCY_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  wire logic             CLK,
    input  wire logic             RESET_N,
    input  wire logic             BAUD_EN,
    input  wire logic             BIT8,
    input  wire logic             PARITY_EN,
    input  wire logic             ODD_N_EVEN,
    uart_tx_fifo_drain_if.master  fifo,
    output logic                  TX,
    output logic                  TX_BUSY
);

    localparam logic [3:0]          c_TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam int                  c_WAIT_W    = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(RD_LATENCY - 1);

    tx_state_t           r_state;
    logic [3:0]          r_tick;
    logic [2:0]          r_bit_cnt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   r_data;
    logic                r_bit8;
    logic                r_par_en;
    logic                r_odd;
    logic                r_tx;
    logic                r_rdb;
    logic                r_busy;

    logic                w_in_frame;
    logic                w_bit_end;
    logic                w_parity;
    logic [2:0]          w_last_bit;

    always_comb begin
        w_in_frame = (r_state == ST_START) || (r_state == ST_DATA) ||
                     (r_state == ST_PARITY) || (r_state == ST_STOP);
        w_bit_end  = w_in_frame && BAUD_EN && (r_tick == c_TICK_LAST);
        w_last_bit = r_bit8 ? 3'd7 : 3'd6;
        w_parity   = frame_parity(r_data, r_bit8, r_odd);
    end

    // TX is registered, so every transition loads the level of the bit that
    // the new state is about to send.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_tick    <= 4'd0;
            r_bit_cnt <= 3'd0;
            r_wait    <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_bit8    <= 1'b0;
            r_par_en  <= 1'b0;
            r_odd     <= 1'b0;
            r_tx      <= 1'b1;
            r_rdb     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            // Baud ticks only matter while a frame is on the line.
            if (w_in_frame && BAUD_EN) begin
                r_tick <= w_bit_end ? 4'd0 : r_tick + 4'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!fifo.FIFO_EMPTY) begin
                        r_rdb   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_READ;
                    end else begin
                        r_rdb   <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READ: begin
                    r_rdb   <= 1'b1;
                    r_wait  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // FIFO_DATA becomes valid RD_LATENCY edges after the
                    // strobe cycle; capture it and the frame format together.
                    if (r_wait == c_WAIT_LAST) begin
                        r_shift  <= fifo.FIFO_DATA;
                        r_data   <= fifo.FIFO_DATA;
                        r_bit8   <= BIT8;
                        r_par_en <= PARITY_EN;
                        r_odd    <= ODD_N_EVEN;
                        r_tick   <= 4'd0;
                        r_tx     <= 1'b0;
                        r_state  <= ST_START;
                    end else begin
                        r_wait   <= r_wait + c_WAIT_W'(1);
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_bit_cnt <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == w_last_bit) begin
                            r_bit_cnt <= 3'd0;
                            if (r_par_en) begin
                                r_tx    <= w_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Chain straight into the next read when more data is
                    // queued so TX_BUSY never drops between frames.
                    if (w_bit_end) begin
                        if (!fifo.FIFO_EMPTY) begin
                            r_rdb   <= 1'b0;
                            r_state <= ST_READ;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign TX            = r_tx;
    assign TX_BUSY       = r_busy;
    assign fifo.FIFO_RDB = r_rdb;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_drain
// Purpose  : Directed self-checking bench for uart_tx_fifo_drain with a
//            two-stage-latency FIFO read model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_drain;
    import coreuart_pkg::*;

    logic CLK = 1'b0;
    logic RESET_N;
    logic BAUD_EN;
    logic BIT8;
    logic PARITY_EN;
    logic ODD_N_EVEN;
    logic TX;
    logic TX_BUSY;

    uart_tx_fifo_drain_if fif();

    uart_tx_fifo_drain dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .BAUD_EN    (BAUD_EN),
        .BIT8       (BIT8),
        .PARITY_EN  (PARITY_EN),
        .ODD_N_EVEN (ODD_N_EVEN),
        .fifo       (fif),
        .TX         (TX),
        .TX_BUSY    (TX_BUSY)
    );

    always #5 CLK = ~CLK;

    // FIFO model: read data appears two edges after the strobe cycle.
    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    logic [7:0] stage1 = 8'd0;

    assign fif.FIFO_EMPTY = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (fif.FIFO_RDB === 1'b0 && wr_ptr != rd_ptr) begin
            stage1 <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end
        fif.FIFO_DATA <= stage1;
    end

    // Strobe monitor.
    int   rd_cnt   = 0;
    int   rd_empty = 0;
    int   rd_wide  = 0;
    logic prev_rdb = 1'b1;

    always @(negedge CLK) begin
        if (fif.FIFO_RDB === 1'b0) begin
            rd_cnt++;
            if (fif.FIFO_EMPTY) rd_empty++;
            if (prev_rdb === 1'b0) rd_wide++;
        end
        prev_rdb = fif.FIFO_RDB;
    end

    // Baud enable: one pulse every third clock.
    int baud_div = 0;
    initial begin
        BAUD_EN = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            baud_div = (baud_div == 2) ? 0 : baud_div + 1;
            BAUD_EN  = (baud_div == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic push_byte(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr      = wr_ptr + 4'd1;
    endtask

    // Samples one frame starting at the first TX-low cycle; each bit lasts
    // until OVERSAMPLE baud pulses have been seen.
    task automatic capture_frame(input int nbits, output logic [10:0] bits,
                                 output int glitches, output int busy_drops,
                                 output bit timeout);
        int guard;
        bits = '0; glitches = 0; busy_drops = 0; timeout = 1'b0; guard = 0;
        while (TX !== 1'b0 && guard < 4000) begin
            @(negedge CLK);
            guard++;
        end
        if (TX !== 1'b0) begin
            timeout = 1'b1;
            return;
        end
        for (int b = 0; b < nbits; b++) begin
            int ticks;
            ticks   = 0;
            guard   = 0;
            bits[b] = TX;
            while (ticks < OVERSAMPLE_DEF && guard < 1000) begin
                if (TX !== bits[b]) glitches++;
                if (TX_BUSY !== 1'b1) busy_drops++;
                if (BAUD_EN) ticks++;
                @(negedge CLK);
                guard++;
            end
            if (ticks < OVERSAMPLE_DEF) timeout = 1'b1;
        end
    endtask

    task automatic test_reset;
        RESET_N = 1'b0; BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
        push_byte(8'hAA);
        repeat (3) @(negedge CLK);
        #1;
        n_checks++; if (TX !== 1'b1) $display("FAIL reset_tx: got %b expected 1", TX); else n_pass++;
        n_checks++; if (fif.FIFO_RDB !== 1'b1) $display("FAIL reset_rdb: got %b expected 1", fif.FIFO_RDB); else n_pass++;
        n_checks++; if (TX_BUSY !== 1'b0) $display("FAIL reset_busy: got %b expected 0", TX_BUSY); else n_pass++;
        n_checks++; if (rd_cnt != 0) $display("FAIL reset_no_strobe: got %0d strobes expected 0", rd_cnt); else n_pass++;
        n_checks++; if (dut.r_state !== ST_IDLE) $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE); else n_pass++;
        wr_ptr = rd_ptr;
        @(posedge CLK); #1;
        RESET_N = 1'b1;
    endtask

    task automatic test_frame(input string name, input logic [7:0] d,
                              input logic b8, input logic pe, input logic odd,
                              input int nbits, input logic [10:0] exp);
        int rd0, guard, gl, bd;
        logic [10:0] bits;
        bit to;
        @(posedge CLK); #1;
        BIT8 = b8; PARITY_EN = pe; ODD_N_EVEN = odd;
        rd0 = rd_cnt;
        push_byte(d);
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (fif.FIFO_RDB !== 1'b0 && guard < 20);
        n_checks++; if (fif.FIFO_RDB !== 1'b0) $display("FAIL %s_strobe: got rdb %b expected 0", name, fif.FIFO_RDB); else n_pass++;
        n_checks++; if (TX_BUSY !== 1'b1) $display("FAIL %s_busy_rise: got %b expected 1", name, TX_BUSY); else n_pass++;
        @(negedge CLK); @(negedge CLK);
        n_checks++; if (TX !== 1'b1) $display("FAIL %s_pre_start: got %b expected 1", name, TX); else n_pass++;
        @(negedge CLK);
        n_checks++; if (TX !== 1'b0) $display("FAIL %s_start_time: got %b expected 0", name, TX); else n_pass++;
        // Format inputs must be ignored once the byte has been captured.
        BIT8 = ~b8; PARITY_EN = ~pe; ODD_N_EVEN = ~odd;
        capture_frame(nbits, bits, gl, bd, to);
        n_checks++; if (to) $display("FAIL %s_timeout: got timeout 1 expected 0", name); else n_pass++;
        n_checks++; if (bits !== exp) $display("FAIL %s_bits: got %h expected %h", name, bits, exp); else n_pass++;
        n_checks++; if (gl != 0 || bd != 0) $display("FAIL %s_bit_len: got %0d glitches %0d busy drops expected 0", name, gl, bd); else n_pass++;
        n_checks++; if (TX_BUSY !== 1'b0) $display("FAIL %s_busy_fall: got %b expected 0", name, TX_BUSY); else n_pass++;
        n_checks++; if (TX !== 1'b1) $display("FAIL %s_idle_tx: got %b expected 1", name, TX); else n_pass++;
        #1;
        n_checks++; if (rd_cnt - rd0 != 1 || rd_empty != 0 || rd_wide != 0)
            $display("FAIL %s_strobes: got %0d/%0d/%0d (reads/empty/wide) expected 1/0/0", name, rd_cnt - rd0, rd_empty, rd_wide);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int rd0, guard, gl, bd, drops;
        logic [10:0] bits;
        bit to;
        @(posedge CLK); #1;
        BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
        rd0 = rd_cnt;
        push_byte(8'h12);
        push_byte(8'h34);
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (fif.FIFO_RDB !== 1'b0 && guard < 20);
        n_checks++; if (fif.FIFO_RDB !== 1'b0) $display("FAIL b2b_strobe1: got rdb %b expected 0", fif.FIFO_RDB); else n_pass++;
        repeat (3) @(negedge CLK);
        capture_frame(10, bits, gl, bd, to);
        n_checks++; if (to || bits !== 11'h224) $display("FAIL b2b_frame1: got %h timeout %0d expected 224", bits, to); else n_pass++;
        n_checks++; if (gl != 0 || bd != 0) $display("FAIL b2b_frame1_len: got %0d glitches %0d busy drops expected 0", gl, bd); else n_pass++;
        n_checks++; if (fif.FIFO_RDB !== 1'b0) $display("FAIL b2b_strobe2_time: got rdb %b expected 0", fif.FIFO_RDB); else n_pass++;
        drops = 0;
        for (int i = 0; i < 3; i++) begin
            if (TX_BUSY !== 1'b1 || TX !== 1'b1) drops++;
            @(negedge CLK);
        end
        n_checks++; if (drops != 0) $display("FAIL b2b_gap: got %0d bad gap cycles expected 0", drops); else n_pass++;
        capture_frame(10, bits, gl, bd, to);
        n_checks++; if (to || bits !== 11'h268) $display("FAIL b2b_frame2: got %h timeout %0d expected 268", bits, to); else n_pass++;
        n_checks++; if (gl != 0 || bd != 0) $display("FAIL b2b_frame2_len: got %0d glitches %0d busy drops expected 0", gl, bd); else n_pass++;
        n_checks++; if (TX_BUSY !== 1'b0) $display("FAIL b2b_busy_fall: got %b expected 0", TX_BUSY); else n_pass++;
        #1;
        n_checks++; if (rd_cnt - rd0 != 2 || rd_empty != 0 || rd_wide != 0)
            $display("FAIL b2b_strobes: got %0d/%0d/%0d (reads/empty/wide) expected 2/0/0", rd_cnt - rd0, rd_empty, rd_wide);
        else n_pass++;
    endtask

    task automatic test_reset_mid_data;
        int rd0, guard, pulses, bad;
        @(posedge CLK); #1;
        BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
        push_byte(8'hFF);
        guard = 0;
        while (TX !== 1'b0 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        n_checks++; if (TX !== 1'b0) $display("FAIL mid_start: got %b expected 0", TX); else n_pass++;
        // 16 start pulses + 3 data bits, then 5 pulses into data bit 3.
        pulses = 0;
        while (pulses < 69) begin
            if (BAUD_EN) pulses++;
            @(negedge CLK);
        end
        n_checks++; if (dut.r_state !== ST_DATA || dut.r_bit_cnt !== 3'd3 || TX !== 1'b1)
            $display("FAIL mid_pre_reset: got state %0d bit %0d tx %b expected 4 3 1", dut.r_state, dut.r_bit_cnt, TX);
        else n_pass++;
        RESET_N = 1'b0;
        @(negedge CLK);
        n_checks++; if (TX !== 1'b1 || TX_BUSY !== 1'b0 || fif.FIFO_RDB !== 1'b1)
            $display("FAIL mid_reset_out: got tx %b busy %b rdb %b expected 1 0 1", TX, TX_BUSY, fif.FIFO_RDB);
        else n_pass++;
        n_checks++; if (dut.r_state !== ST_IDLE || dut.r_tick !== 4'd0 || dut.r_bit_cnt !== 3'd0)
            $display("FAIL mid_reset_state: got state %0d tick %0d bit %0d expected 0 0 0", dut.r_state, dut.r_tick, dut.r_bit_cnt);
        else n_pass++;
        #1;
        rd0 = rd_cnt;
        RESET_N = 1'b1;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (TX !== 1'b1 || fif.FIFO_RDB !== 1'b1) bad++;
        end
        #1;
        n_checks++; if (bad != 0) $display("FAIL mid_after_idle: got %0d non-idle cycles expected 0", bad); else n_pass++;
        n_checks++; if (rd_cnt != rd0) $display("FAIL mid_after_strobes: got %0d expected 0", rd_cnt - rd0); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_frame("8n1_55", 8'h55, 1'b1, 1'b0, 1'b0, 10, 11'h2AA);
        test_frame("8e1_a3", 8'hA3, 1'b1, 1'b1, 1'b0, 11, 11'h546);
        test_frame("8o1_a3", 8'hA3, 1'b1, 1'b1, 1'b1, 11, 11'h746);
        test_frame("7n1_c1", 8'hC1, 1'b0, 1'b0, 1'b0,  9, 11'h182);
        test_frame("7o1_c1", 8'hC1, 1'b0, 1'b1, 1'b1, 10, 11'h382);
        test_back_to_back;
        test_reset_mid_data;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
